// File: rtl/regbank_cmd_ctrl_if.sv
// Command/response channel between an upstream requester and regbank_cmd_ctrl.
// master: the requester side; slave: the controller side.
interface regbank_cmd_ctrl_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/regbank_cmd_ctrl.sv
// Upstream command controller for the 14 x 16-bit register bank.
// Takes one read/write command at a time, range-checks the address, drives the
// bank strobes, captures read data and returns one response per command.
// Optional feature macro: REGBANK_CMD_STATS_EN adds saturating write/read/error
// response counters (stat_*_cnt_o).
module regbank_cmd_ctrl #(
   parameter int unsigned NUM_REGS = 14,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DATA_W   = 16
`ifdef REGBANK_CMD_STATS_EN
   ,
   parameter int unsigned STAT_W   = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   regbank_cmd_ctrl_if.slave    bus_io,
   output logic                 busy_o,
   output logic                 bank_write_en_o,
   output logic                 bank_read_en_o,
   output logic [ADDR_W-1:0]    bank_addr_o,
   output logic [DATA_W-1:0]    bank_data_in_o,
`ifdef REGBANK_CMD_STATS_EN
   output logic [STAT_W-1:0]    stat_wr_cnt_o,
   output logic [STAT_W-1:0]    stat_rd_cnt_o,
   output logic [STAT_W-1:0]    stat_err_cnt_o,
`endif
   input  logic [DATA_W-1:0]    bank_data_out_i
);

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StRd,
      StRdCap,
      StResp
   } state_e;

   // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] NumRegsCmp = (ADDR_W + 1)'(NUM_REGS);

   state_e state_q, state_d;

   logic              cmd_ready_q, cmd_ready_d;
   logic              busy_q, busy_d;
   logic              bank_write_en_q, bank_write_en_d;
   logic              bank_read_en_q, bank_read_en_d;
   logic [ADDR_W-1:0] bank_addr_q, bank_addr_d;
   logic [DATA_W-1:0] bank_data_in_q, bank_data_in_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   logic cmd_accept;
   logic addr_ok;
   logic rsp_accept;

   assign cmd_accept = (state_q == StIdle) && bus_io.cmd_valid;
   assign addr_ok    = ({1'b0, bus_io.cmd_addr} < NumRegsCmp);
   assign rsp_accept = (state_q == StResp) && bus_io.rsp_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_accept) begin
               if (!addr_ok) begin
                  state_d = StResp;
               end else if (bus_io.cmd_write) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StWr:    state_d = StResp;
         StRd:    state_d = StRdCap;
         StRdCap: state_d = StResp;
         StResp: begin
            if (bus_io.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs; strobes and flags follow the next state so
   // they are aligned with the cycle the FSM spends in that state.
   always_comb begin
      cmd_ready_d     = (state_d == StIdle);
      busy_d          = (state_d != StIdle);
      bank_write_en_d = (state_d == StWr);
      bank_read_en_d  = (state_d == StRd);
      rsp_valid_d     = (state_d == StResp);
      bank_addr_d     = bank_addr_q;
      bank_data_in_d  = bank_data_in_q;
      rsp_err_d       = rsp_err_q;
      rsp_rdata_d     = rsp_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_accept) begin
               rsp_err_d   = !addr_ok;
               rsp_rdata_d = '0;
               // Erroring commands never touch the bank pins.
               if (addr_ok) begin
                  bank_addr_d = bus_io.cmd_addr;
                  if (bus_io.cmd_write) begin
                     bank_data_in_d = bus_io.cmd_wdata;
                  end
               end
            end
         end
         StRdCap: rsp_rdata_d = bank_data_out_i;
         StResp: begin
            if (rsp_accept) begin
               rsp_err_d   = 1'b0;
               rsp_rdata_d = '0;
            end
         end
         default: ;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_ready_q     <= 1'b1;
         busy_q          <= 1'b0;
         bank_write_en_q <= 1'b0;
         bank_read_en_q  <= 1'b0;
         bank_addr_q     <= '0;
         bank_data_in_q  <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_err_q       <= 1'b0;
         rsp_rdata_q     <= '0;
      end else begin
         cmd_ready_q     <= cmd_ready_d;
         busy_q          <= busy_d;
         bank_write_en_q <= bank_write_en_d;
         bank_read_en_q  <= bank_read_en_d;
         bank_addr_q     <= bank_addr_d;
         bank_data_in_q  <= bank_data_in_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_err_q       <= rsp_err_d;
         rsp_rdata_q     <= rsp_rdata_d;
      end
   end

   assign bus_io.cmd_ready = cmd_ready_q;
   assign bus_io.rsp_valid = rsp_valid_q;
   assign bus_io.rsp_err   = rsp_err_q;
   assign bus_io.rsp_rdata = rsp_rdata_q;
   assign busy_o           = busy_q;
   assign bank_write_en_o  = bank_write_en_q;
   assign bank_read_en_o   = bank_read_en_q;
   assign bank_addr_o      = bank_addr_q;
   assign bank_data_in_o   = bank_data_in_q;

`ifdef REGBANK_CMD_STATS_EN
   logic              is_wr_q;
   logic [STAT_W-1:0] stat_wr_q, stat_rd_q, stat_err_q;

   // Response statistics, counted on the response handshake and saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_wr_q    <= 1'b0;
         stat_wr_q  <= '0;
         stat_rd_q  <= '0;
         stat_err_q <= '0;
      end else begin
         if (cmd_accept) begin
            is_wr_q <= bus_io.cmd_write;
         end
         if (rsp_accept) begin
            if (rsp_err_q) begin
               if (stat_err_q != '1) stat_err_q <= stat_err_q + 1'b1;
            end else if (is_wr_q) begin
               if (stat_wr_q != '1) stat_wr_q <= stat_wr_q + 1'b1;
            end else begin
               if (stat_rd_q != '1) stat_rd_q <= stat_rd_q + 1'b1;
            end
         end
      end
   end

   assign stat_wr_cnt_o  = stat_wr_q;
   assign stat_rd_cnt_o  = stat_rd_q;
   assign stat_err_cnt_o = stat_err_q;
`endif

endmodule

// File: tb/tb_regbank_cmd_ctrl.sv
// Directed self-checking bench for regbank_cmd_ctrl with a behavioural 16 x 16 bank model.
module tb_regbank_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy;
   logic        bank_we, bank_re;
   logic [3:0]  bank_addr;
   logic [15:0] bank_din;
   logic [15:0] bank_dout;
`ifdef REGBANK_CMD_STATS_EN
   logic [15:0] stat_wr, stat_rd, stat_err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int we_cycles = 0;
   int re_cycles = 0;
   int both_cycles = 0;

   logic [15:0] mem [16];

   always #5 clk = ~clk;

   regbank_cmd_ctrl_if #(.ADDR_W(4), .DATA_W(16)) bus ();

   regbank_cmd_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .bus_io          (bus),
      .busy_o          (busy),
      .bank_write_en_o (bank_we),
      .bank_read_en_o  (bank_re),
      .bank_addr_o     (bank_addr),
      .bank_data_in_o  (bank_din),
`ifdef REGBANK_CMD_STATS_EN
      .stat_wr_cnt_o   (stat_wr),
      .stat_rd_cnt_o   (stat_rd),
      .stat_err_cnt_o  (stat_err),
`endif
      .bank_data_out_i (bank_dout)
   );

   // Bank model: registered read data, cleared by the shared reset.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
         bank_dout <= 16'h0000;
      end else begin
         if (bank_we) mem[bank_addr] <= bank_din;
         if (bank_re) bank_dout <= mem[bank_addr];
      end
   end

   // Strobe activity monitor.
   always @(posedge clk) begin
      if (bank_we) we_cycles <= we_cycles + 1;
      if (bank_re) re_cycles <= re_cycles + 1;
      if (bank_we && bank_re) both_cycles <= both_cycles + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Present one command at a negedge; return once rsp_valid is seen (or the budget runs out).
   task automatic issue(input logic wr, input logic [3:0] addr, input logic [15:0] wdata,
                        output int lat);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.rsp_valid) break;
      end
   endtask

   // Complete the response handshake and check the channel returns to idle.
   task automatic respond();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      @(negedge clk);
      check_eq("rsp_valid_clr", {31'b0, bus.rsp_valid}, 32'd0);
      check_eq("rsp_rdata_clr", {16'b0, bus.rsp_rdata}, 32'd0);
      check_eq("cmd_ready_back", {31'b0, bus.cmd_ready}, 32'd1);
   endtask

   task automatic do_cmd(input string tag, input logic wr, input logic [3:0] addr,
                         input logic [15:0] wdata, input int exp_lat,
                         input logic exp_err, input logic [15:0] exp_rdata);
      int lat;
      issue(wr, addr, wdata, lat);
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
      check_eq({tag, "_rdata"}, {16'b0, bus.rsp_rdata}, {16'b0, exp_rdata});
      respond();
   endtask

   initial begin
      int lat;
      int we0, re0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 4'd0;
      bus.cmd_wdata = 16'h0000;
      bus.rsp_ready = 1'b0;

      // Reset state, held while rst is high.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
      check_eq("rst_outs", {28'b0, bus.rsp_valid, bus.rsp_err, busy, bank_we | bank_re}, 32'd0);
      check_eq("rst_bus", {12'b0, bank_addr, bank_din}, 32'd0);
      rst = 1'b0;

      // 1. Fresh bank reads back zero with latency 3.
      for (int a = 0; a < 14; a++) begin
         do_cmd("rd_init", 1'b0, 4'(a), 16'hDEAD, 3, 1'b0, 16'h0000);
      end

      // 2. Single write pulse then read back.
      we0 = we_cycles;
      do_cmd("wr5", 1'b1, 4'd5, 16'hA5A5, 2, 1'b0, 16'h0000);
      check_eq("wr5_pulses", we_cycles - we0, 32'd1);
      check_eq("wr5_mem", {16'b0, mem[5]}, 32'h0000A5A5);
      do_cmd("rd5", 1'b0, 4'd5, 16'h0000, 3, 1'b0, 16'hA5A5);
      do_cmd("wr13", 1'b1, 4'd13, 16'h0F0F, 2, 1'b0, 16'h0000);
      do_cmd("rd13", 1'b0, 4'd13, 16'h0000, 3, 1'b0, 16'h0F0F);
      do_cmd("rd0", 1'b0, 4'd0, 16'h0000, 3, 1'b0, 16'h0000);

      // 3. Out-of-range addresses: error after one cycle, bank untouched.
      we0 = we_cycles;
      re0 = re_cycles;
      do_cmd("wr14", 1'b1, 4'd14, 16'h1234, 1, 1'b1, 16'h0000);
      do_cmd("rd15", 1'b0, 4'd15, 16'h0000, 1, 1'b1, 16'h0000);
      check_eq("err_no_we", we_cycles - we0, 32'd0);
      check_eq("err_no_re", re_cycles - re0, 32'd0);
      check_eq("err_addr_hold", {28'b0, bank_addr}, 32'd0);
      check_eq("err_din_hold", {16'b0, bank_din}, 32'h00000F0F);

      // 4. Response back-pressure.
      do_cmd("wr1", 1'b1, 4'd1, 16'hFFFF, 2, 1'b0, 16'h0000);
      issue(1'b0, 4'd1, 16'h0000, lat);
      check_eq("bp_lat", lat, 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp_hold", {14'b0, bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata},
                  {14'b0, 1'b1, 1'b0, 16'hFFFF});
      end
      respond();

      // 5. Reset during the RD cycle drops the command.
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 4'd1;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      check_eq("rd_cycle_re", {31'b0, bank_re}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("mid_rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
      check_eq("mid_rst_outs", {28'b0, bus.rsp_valid, busy, bank_we, bank_re}, 32'd0);
      check_eq("mid_rst_bus", {bank_addr, bus.rsp_rdata, 12'b0}, 32'd0);
      repeat (4) @(negedge clk);
      check_eq("mid_rst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);

`ifdef REGBANK_CMD_STATS_EN
      // 6. Statistics after reset.
      do_cmd("st_wr_a", 1'b1, 4'd2, 16'h1111, 2, 1'b0, 16'h0000);
      do_cmd("st_wr_b", 1'b1, 4'd3, 16'h2222, 2, 1'b0, 16'h0000);
      do_cmd("st_wr_c", 1'b1, 4'd4, 16'h3333, 2, 1'b0, 16'h0000);
      do_cmd("st_rd_a", 1'b0, 4'd2, 16'h0000, 3, 1'b0, 16'h1111);
      do_cmd("st_rd_b", 1'b0, 4'd4, 16'h0000, 3, 1'b0, 16'h3333);
      do_cmd("st_bad", 1'b1, 4'd15, 16'h4444, 1, 1'b1, 16'h0000);
      check_eq("stat_wr", {16'b0, stat_wr}, 32'd3);
      check_eq("stat_rd", {16'b0, stat_rd}, 32'd2);
      check_eq("stat_err", {16'b0, stat_err}, 32'd1);
`endif

      check_eq("strobe_overlap", both_cycles, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
